// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: register offsets, source-ID type and helpers shared by the interrupt controller.
package irq_ctrl_pkg;
  localparam logic [2:0] IRQ_OFF_PENDING = 3'd0;
  localparam logic [2:0] IRQ_OFF_ENABLE  = 3'd1;
  localparam logic [2:0] IRQ_OFF_MODE    = 3'd2;
  localparam logic [2:0] IRQ_OFF_CLAIM   = 3'd3;
  localparam logic [2:0] IRQ_OFF_SWSET   = 3'd4;
  localparam int         IRQ_MAX_SRC     = 31;
  localparam int         IRQ_ID_W        = $clog2(IRQ_MAX_SRC + 1);
  typedef logic [IRQ_ID_W-1:0] irq_id_t;
  localparam irq_id_t    IRQ_ID_NONE     = '0;
  // Source index i is exposed to software as ID i+1, keeping 0 for "none".
  function automatic irq_id_t irq_src_id(input int idx);
    return irq_id_t'(idx + 1);
  endfunction
endpackage

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: single-cycle word bus between the cpu and the interrupt controller.
interface irq_ctrl_if;
  logic        bus_sel;
  logic        bus_we;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  modport master (output bus_sel, bus_we, bus_addr, bus_wdata, input bus_rdata);
  modport slave  (input bus_sel, bus_we, bus_addr, bus_wdata, output bus_rdata);
endinterface

// File: rtl/irq_gateway.sv
// irq_gateway: one source's synchroniser, edge/level trigger, pending latch and in-service gate.
module irq_gateway #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic mode,
  input  logic set_sw,
  input  logic claim,
  input  logic complete,
  output logic pending
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   pend_q, pend_d;
  logic                   insvc_q, insvc_d;
  logic                   s, trig;

  // Edge history tracks the line even while in service so a held line cannot re-trigger.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], src};
    s       = sync_q[SYNC_STAGES-1];
    prev_d  = s;
    trig    = (mode ? s & ~prev_q : s) | set_sw;
    pend_d  = claim ? 1'b0 : pend_q | (trig & ~insvc_q);
    insvc_d = claim ? 1'b1 : complete ? 1'b0 : insvc_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pend_q  <= 1'b0;
      insvc_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pend_q  <= pend_d;
      insvc_q <= insvc_d;
    end
  end

  assign pending = pend_q;
endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: external interrupt controller with per-source gateways, fixed lowest-index priority
// and claim/complete over a word bus.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_in,
  irq_ctrl_if.slave          bus,
  output logic               external_int,
  output irq_id_t            claim_id
);
  logic [NUM_SRC-1:0] pending, set_sw, claim, complete;
  logic [NUM_SRC-1:0] enable_q, enable_d, mode_q, mode_d;
  logic               ext_q, ext_d;
  logic               rd, wr, claim_rd;
  irq_id_t            win_id, claim_id_q, claim_id_d;
  logic [31:0]        rdata_q, rdata_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    irq_gateway #(.SYNC_STAGES(SYNC_STAGES)) u_gw (
      .clk      (clk),
      .reset    (reset),
      .src      (src_in[i]),
      .mode     (mode_q[i]),
      .set_sw   (set_sw[i]),
      .claim    (claim[i]),
      .complete (complete[i]),
      .pending  (pending[i])
    );
  end

  assign rd       = bus.bus_sel & ~bus.bus_we;
  assign wr       = bus.bus_sel & bus.bus_we;
  assign claim_rd = rd && bus.bus_addr == IRQ_OFF_CLAIM;

  always_comb begin
    win_id = IRQ_ID_NONE;
    for (int j = NUM_SRC - 1; j >= 0; j--)
      if (pending[j] && enable_q[j]) win_id = irq_src_id(j);
  end

  // Completing an ID that is out of range or not in service matches no gateway and is ignored there.
  always_comb begin
    claim    = '0;
    complete = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      claim[j]    = claim_rd && win_id == irq_src_id(j);
      complete[j] = wr && bus.bus_addr == IRQ_OFF_CLAIM && bus.bus_wdata == 32'(j + 1);
    end
    set_sw     = (wr && bus.bus_addr == IRQ_OFF_SWSET) ? bus.bus_wdata[NUM_SRC-1:0] : '0;
    enable_d   = (wr && bus.bus_addr == IRQ_OFF_ENABLE) ? bus.bus_wdata[NUM_SRC-1:0] : enable_q;
    mode_d     = (wr && bus.bus_addr == IRQ_OFF_MODE) ? bus.bus_wdata[NUM_SRC-1:0] : mode_q;
    ext_d      = |(pending & enable_q);
    claim_id_d = (claim_rd && win_id != IRQ_ID_NONE) ? win_id : claim_id_q;
    rdata_d    = !rd                             ? 32'd0 :
                 bus.bus_addr == IRQ_OFF_PENDING ? 32'(pending) :
                 bus.bus_addr == IRQ_OFF_ENABLE  ? 32'(enable_q) :
                 bus.bus_addr == IRQ_OFF_MODE    ? 32'(mode_q) :
                 bus.bus_addr == IRQ_OFF_CLAIM   ? 32'(win_id) : 32'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q   <= '0;
      mode_q     <= '0;
      ext_q      <= 1'b0;
      claim_id_q <= IRQ_ID_NONE;
      rdata_q    <= '0;
    end else begin
      enable_q   <= enable_d;
      mode_q     <= mode_d;
      ext_q      <= ext_d;
      claim_id_q <= claim_id_d;
      rdata_q    <= rdata_d;
    end
  end

  assign external_int  = ext_q;
  assign claim_id      = claim_id_q;
  assign bus.bus_rdata = rdata_q;
endmodule
